// File: rtl/matvec2x2_transpose_seq_pkg.sv
// Shared types and default widths for the 2x2 transpose matrix-vector backward block.
package matvec2x2_transpose_seq_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [1:0] step_t;

    localparam step_t STEP_LAST = 2'd3;

endpackage

// File: rtl/matvec2x2_transpose_seq_signed_mac.sv
// Combinational signed multiply-accumulate: sum = acc + sext/trunc(a*b), wrapping modulo 2^ACC_W.
module matvec2x2_transpose_seq_signed_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  acc,
    output logic [ACC_W-1:0]  sum
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] prod;
    logic        [ACC_W-1:0]  prod_ext;

    assign prod = $signed(a) * $signed(b);

    generate
        if (ACC_W > PROD_W) begin : g_sext
            assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        end else if (ACC_W == PROD_W) begin : g_same
            assign prod_ext = prod;
        end else begin : g_trunc
            assign prod_ext = prod[ACC_W-1:0];
        end
    endgenerate

    assign sum = acc + prod_ext;

endmodule

// File: rtl/matvec2x2_transpose_seq.sv
// z = A^T * e for a 2x2 signed matrix, using one shared MAC sequenced over four cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | in_ready=1, waiting for an operand set
// MAC     | one product per edge, step 0..3 (acc1 on 0-1, acc2 on 2-3)
// DONE    | out_valid=1, z1/z2 held until out_ready
module matvec2x2_transpose_seq
    import matvec2x2_transpose_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a11,
    input  logic [DATA_W-1:0] a12,
    input  logic [DATA_W-1:0] a21,
    input  logic [DATA_W-1:0] a22,
    input  logic [DATA_W-1:0] e1,
    input  logic [DATA_W-1:0] e2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  z1,
    output logic [ACC_W-1:0]  z2
);

    state_t            state;
    step_t             step;
    logic [DATA_W-1:0] r_a11, r_a12, r_a21, r_a22, r_e1, r_e2;
    logic [ACC_W-1:0]  acc1, acc2;

    logic [DATA_W-1:0] mac_a, mac_b;
    logic [ACC_W-1:0]  mac_acc, mac_sum;

    // Transposed access: acc1 takes column 1 of A (a11, a21), acc2 column 2 (a12, a22).
    always_comb begin
        mac_a   = r_a11;
        mac_b   = r_e1;
        mac_acc = acc1;
        case (step)
            2'd0: begin mac_a = r_a11; mac_b = r_e1; mac_acc = acc1; end
            2'd1: begin mac_a = r_a21; mac_b = r_e2; mac_acc = acc1; end
            2'd2: begin mac_a = r_a12; mac_b = r_e1; mac_acc = acc2; end
            default: begin mac_a = r_a22; mac_b = r_e2; mac_acc = acc2; end
        endcase
    end

    matvec2x2_transpose_seq_signed_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .a   (mac_a),
        .b   (mac_b),
        .acc (mac_acc),
        .sum (mac_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            step      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            r_a11     <= '0;
            r_a12     <= '0;
            r_a21     <= '0;
            r_a22     <= '0;
            r_e1      <= '0;
            r_e2      <= '0;
            acc1      <= '0;
            acc2      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a11    <= a11;
                        r_a12    <= a12;
                        r_a21    <= a21;
                        r_a22    <= a22;
                        r_e1     <= e1;
                        r_e2     <= e2;
                        acc1     <= '0;
                        acc2     <= '0;
                        step     <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (step[1] == 1'b0) acc1 <= mac_sum;
                    else                 acc2 <= mac_sum;
                    step <= step_t'(step + 2'd1);
                    if (step == STEP_LAST) begin
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign z1 = acc1;
    assign z2 = acc2;

endmodule

// File: tb/tb_matvec2x2_transpose_seq.sv
// Directed bench for matvec2x2_transpose_seq with hand-computed expected results.
module tb_matvec2x2_transpose_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a11, a12, a21, a22, e1, e2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z1, z2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matvec2x2_transpose_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a11       (a11),
        .a12       (a12),
        .a21       (a21),
        .a22       (a22),
        .e1        (e1),
        .e2        (e2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z1        (z1),
        .z2        (z2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int va11, input int va12, input int va21, input int va22,
                           input int ve1, input int ve2);
        a11 = 8'(va11); a12 = 8'(va12); a21 = 8'(va21); a22 = 8'(va22);
        e1  = 8'(ve1);  e2  = 8'(ve2);
    endtask

    // Waits for in_ready, then takes the accept edge; returns the cycle of that edge.
    task automatic accept(input string tag, output int acc_cyc);
        int n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        if (n >= 50) check({tag, "_accept_timeout"}, 0, 1);
        tick();
        acc_cyc = cyc;
    endtask

    // Counts edges from the accept edge until out_valid is seen.
    task automatic wait_out(input string tag, output int lat);
        lat = 0;
        do begin tick(); lat++; end while (!out_valid && lat < 50);
        if (!out_valid) check({tag, "_out_timeout"}, 0, 1);
    endtask

    task automatic do_op(input string tag,
                         input int va11, input int va12, input int va21, input int va22,
                         input int ve1, input int ve2,
                         input logic [15:0] exp_z1, input logic [15:0] exp_z2);
        int t, lat;
        set_ops(va11, va12, va21, va22, ve1, ve2);
        in_valid = 1'b1;
        accept(tag, t);
        in_valid = 1'b0;
        set_ops(0, 0, 0, 0, 0, 0);
        wait_out(tag, lat);
        check({tag, "_latency"}, lat, 4);
        check({tag, "_z1"}, z1, exp_z1);
        check({tag, "_z2"}, z2, exp_z2);
        tick();
        check({tag, "_post_valid_ready"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        int t, lat, t_prev;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_ops(0, 0, 0, 0, 0, 0);
        tick(); tick();
        check("rst_state", {in_ready, out_valid, z1, z2}, {1'b1, 1'b0, 16'h0, 16'h0});
        rst_n = 1'b1;
        tick();

        do_op("basic", 1, 2, 3, 4, 5, 6, 16'h0017, 16'h0022);
        do_op("mixed", -1, 127, 2, -3, 10, -20, 16'hFFCE, 16'h0532);
        do_op("wrap", -128, -128, -128, -128, -128, -128, 16'h8000, 16'h8000);
        do_op("max", 127, 0, 0, 0, 127, 0, 16'h3F01, 16'h0000);

        // backpressure: z1 = 3*7 + 5*-2 = 11, z2 = -4*7 + 6*-2 = -40
        out_ready = 1'b0;
        set_ops(3, -4, 5, 6, 7, -2);
        in_valid = 1'b1;
        accept("bp", t);
        set_ops(9, 9, 9, 9, 9, 9);
        wait_out("bp", lat);
        check("bp_latency", lat, 4);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold", {out_valid, in_ready, z1, z2}, {1'b1, 1'b0, 16'h000B, 16'hFFD8});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release", {out_valid, in_ready, z1, z2}, {1'b0, 1'b1, 16'h000B, 16'hFFD8});
        tick();
        check("bp_single_hs", {out_valid, in_ready}, 2'b01);

        // reset while at step 2
        set_ops(1, 2, 3, 4, 5, 6);
        in_valid = 1'b1;
        accept("rst_mid", t);
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        check("rst_mid_state", {out_valid, in_ready, z1, z2}, {1'b0, 1'b1, 16'h0, 16'h0});
        rst_n = 1'b1;
        tick();
        check("rst_mid_no_pulse", out_valid, 1'b0);
        do_op("after_rst", 1, 2, 3, 4, 5, 6, 16'h0017, 16'h0022);

        // back-to-back with in_valid held
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_ops(1, 2, 3, 4, 5, 6);
        accept("b2b0", t_prev);
        set_ops(-1, 127, 2, -3, 10, -20);
        wait_out("b2b0", lat);
        check("b2b0_z", {z1, z2}, {16'h0017, 16'h0022});
        accept("b2b1", t);
        check("b2b1_interval", t - t_prev, 6);
        t_prev = t;
        set_ops(127, 0, 0, 0, 127, 0);
        wait_out("b2b1", lat);
        check("b2b1_z", {z1, z2}, {16'hFFCE, 16'h0532});
        accept("b2b2", t);
        check("b2b2_interval", t - t_prev, 6);
        in_valid = 1'b0;
        wait_out("b2b2", lat);
        check("b2b2_z", {z1, z2}, {16'h3F01, 16'h0000});
        tick();
        check("b2b_end", {out_valid, in_ready}, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
